ahb_apb_bridge_slave: RTL

AHB-Lite responder that terminates the AHB transfers driven into the bridge and replays each beat as an APB (AMBA 2, no PREADY) access on one of `NUM_SLV` peripherals. It sits between the AHB driver/monitor interface (`HSELAPBif`, `HREADYin`, `HREADYout`, `HRESP`, `HRDATA`) and the APB side of the bridge. It is the DUT-side counterpart of the AHB driver and is also the reference model for scoreboard timing.

---
 rtl/ahb_apb_pkg.sv | 24 ++
 rtl/apb_slave_decoder.sv | 32 +++
 rtl/ahb_apb_bridge_slave.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ahb_apb_pkg.sv
// Shared encodings and defaults for the AHB-Lite to APB bridge responder.
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [31:0] DEF_ADDR_BASE = 32'h8000_0000;
  localparam logic [31:0] DEF_SLV_SIZE  = 32'h0400_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ENABLE,
    ST_ERR1,
    ST_ERR2
  } bridge_state_t;

endpackage

// File: rtl/apb_slave_decoder.sv
// Combinational APB window decode: HADDR -> in-range flag and one-hot peripheral select.
module apb_slave_decoder
  import ahb_apb_pkg::*;
#(
  parameter int unsigned NUM_SLV   = 4,
  parameter logic [31:0] ADDR_BASE = DEF_ADDR_BASE,
  parameter logic [31:0] SLV_SIZE  = DEF_SLV_SIZE
) (
  input  logic [31:0]        haddr,
  output logic               in_range,
  output logic [NUM_SLV-1:0] sel
);

  localparam int unsigned SIZE_LOG2 = $clog2(SLV_SIZE);
  // One bit wider than the bus so a window reaching 4 GiB still compares correctly.
  localparam logic [32:0] SPAN = 33'(NUM_SLV) << SIZE_LOG2;

  logic [31:0] offset;
  logic [31:0] idx;

  assign offset   = haddr - ADDR_BASE;
  assign idx      = offset >> SIZE_LOG2;
  assign in_range = (haddr >= ADDR_BASE) && ({1'b0, offset} < SPAN);

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_SLV; i++) begin
      sel[i] = in_range && (idx == 32'(i));
    end
  end

endmodule

// File: rtl/ahb_apb_bridge_slave.sv
// AHB-Lite responder replaying each accepted beat as an AMBA 2 APB access,
// with a two-cycle ERROR response for addresses outside the APB window.
module ahb_apb_bridge_slave
  import ahb_apb_pkg::*;
#(
  parameter int unsigned NUM_SLV   = 4,
  parameter logic [31:0] ADDR_BASE = DEF_ADDR_BASE,
  parameter logic [31:0] SLV_SIZE  = DEF_SLV_SIZE
) (
  input  logic               clock,
  input  logic               HRESET,
  input  logic               HSELAPBif,
  input  logic               HREADYin,
  input  logic               HWRITE,
  input  logic [1:0]         HTRANS,
  input  logic [31:0]        HADDR,
  input  logic [31:0]        HWDATA,
  input  logic [2:0]         HSIZE,
  input  logic [2:0]         HBURST,
  output logic               HREADYout,
  output logic [1:0]         HRESP,
  output logic [31:0]        HRDATA,
  output logic [NUM_SLV-1:0] PSELx,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [31:0]        PADDR,
  output logic [31:0]        PWDATA,
  input  logic [31:0]        PRDATA
);

  bridge_state_t state, next_state;

  logic               valid;
  logic               in_range;
  logic [NUM_SLV-1:0] dec_sel;
  logic [NUM_SLV-1:0] sel_q;
  logic               accept;
  logic               capture_wdata;
  bridge_state_t      sample_state;
  logic               unused_ahb;

  // Size and burst type never change sequencing; every beat is handled alike.
  assign unused_ahb = ^{HSIZE, HBURST};

  assign valid = HSELAPBif && HREADYin &&
                 ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  apb_slave_decoder #(
    .NUM_SLV   (NUM_SLV),
    .ADDR_BASE (ADDR_BASE),
    .SLV_SIZE  (SLV_SIZE)
  ) u_decoder (
    .haddr    (HADDR),
    .in_range (in_range),
    .sel      (dec_sel)
  );

  always_ff @(posedge clock) begin
    if (HRESET) begin
      state  <= ST_IDLE;
      sel_q  <= '0;
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        sel_q  <= dec_sel;
        PADDR  <= HADDR;
        PWRITE <= HWRITE;
      end
      if (capture_wdata) begin
        PWDATA <= HWDATA;
      end
    end
  end

  // IDLE, ENABLE and ERR2 all accept a new address phase identically.
  always_comb begin
    sample_state = ST_IDLE;
    if (valid) begin
      if (in_range) sample_state = HWRITE ? ST_WDATA : ST_SETUP;
      else          sample_state = ST_ERR1;
    end
  end

  always_comb begin
    next_state    = state;
    accept        = 1'b0;
    capture_wdata = 1'b0;
    PSELx         = '0;
    PENABLE       = 1'b0;
    HREADYout     = 1'b1;
    HRESP         = HRESP_OKAY;
    HRDATA        = '0;
    case (state)
      ST_IDLE: begin
        next_state = sample_state;
        accept     = valid && in_range;
      end
      ST_WDATA: begin
        HREADYout     = 1'b0;
        capture_wdata = 1'b1;
        next_state    = ST_SETUP;
      end
      ST_SETUP: begin
        PSELx      = sel_q;
        HREADYout  = 1'b0;
        next_state = ST_ENABLE;
      end
      ST_ENABLE: begin
        PSELx      = sel_q;
        PENABLE    = 1'b1;
        if (!PWRITE) HRDATA = PRDATA;
        next_state = sample_state;
        accept     = valid && in_range;
      end
      ST_ERR1: begin
        HRESP      = HRESP_ERROR;
        HREADYout  = 1'b0;
        next_state = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP      = HRESP_ERROR;
        next_state = sample_state;
        accept     = valid && in_range;
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule
